// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: owns the count register and sweeps MIN_VAL..MAX_VAL..MIN_VAL on
// prescaler ticks, with pause, abort, auto-repeat and a saturating completed-sweep counter.
module updown_sweep_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 9,
    parameter int unsigned SW_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             progressive,
    input  logic             regressive,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_repeat,
    output logic [WIDTH-1:0] count,
    output logic             forward,
    output logic             enable,
    output logic             finish,
    output logic [SW_W-1:0]  sweep_cnt,
    output logic [1:0]       state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [WIDTH-1:0] CNT_MIN = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX_VAL);
    localparam logic [SW_W-1:0]  SW_SAT  = {SW_W{1'b1}};

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] count_nxt, count_inc, count_dec;
    logic             forward_nxt, finish_nxt;
    logic [SW_W-1:0]  sweep_nxt;

    assign count_inc = count + WIDTH'(1);
    assign count_dec = count - WIDTH'(1);

    // Sweeping is only visible downstream while not frozen by pause.
    assign enable  = ((state == S_UP) || (state == S_DOWN)) && !pause;
    assign state_o = state;

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= CNT_MIN;
            forward   <= 1'b1;
            finish    <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            forward   <= forward_nxt;
            finish    <= finish_nxt;
            sweep_cnt <= sweep_nxt;
        end
    end

    // Next-state and output logic; abort beats pause beats normal sequencing.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        forward_nxt = forward;
        finish_nxt  = 1'b0;
        sweep_nxt   = sweep_cnt;

        if (abort) begin
            state_nxt   = S_IDLE;
            count_nxt   = CNT_MIN;
            forward_nxt = 1'b1;
        end else if (!pause) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt   = S_UP;
                        count_nxt   = CNT_MIN;
                        forward_nxt = 1'b1;
                    end
                end
                S_UP: begin
                    if (tick) begin
                        count_nxt = count_inc;
                        if (count_inc == CNT_MAX) begin
                            finish_nxt  = 1'b1;
                            state_nxt   = S_DOWN;
                            forward_nxt = 1'b0;
                        end
                    end
                end
                S_DOWN: begin
                    if (tick) begin
                        count_nxt = count_dec;
                        if (count_dec == CNT_MIN) begin
                            finish_nxt  = 1'b1;
                            state_nxt   = auto_repeat ? S_UP : S_HOLD;
                            forward_nxt = auto_repeat;
                            if (sweep_cnt != SW_SAT) begin
                                sweep_nxt = sweep_cnt + SW_W'(1);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    // A command load swallows any tick arriving on the same edge.
                    if (progressive) begin
                        state_nxt   = S_UP;
                        count_nxt   = CNT_MIN;
                        forward_nxt = 1'b1;
                    end else if (regressive) begin
                        state_nxt   = S_DOWN;
                        count_nxt   = CNT_MAX;
                        forward_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: behavioural sweep model checked every cycle plus directed
// literal expectations.
module tb_updown_sweep_ctrl;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MIN_VAL = 0;
    localparam int unsigned MAX_VAL = 9;
    localparam int unsigned SW_W    = 4;
    localparam int          SW_TOP  = (1 << SW_W) - 1;

    localparam int P_IDLE = 0;
    localparam int P_UP   = 1;
    localparam int P_DOWN = 2;
    localparam int P_HOLD = 3;

    logic             clk;
    logic             reset;
    logic             tick, start, progressive, regressive, pause, abort, auto_repeat;
    logic [WIDTH-1:0] count;
    logic             forward, enable, finish;
    logic [SW_W-1:0]  sweep_cnt;
    logic [1:0]       state_o;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    updown_sweep_ctrl #(
        .WIDTH(WIDTH), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .SW_W(SW_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .progressive(progressive), .regressive(regressive), .pause(pause),
        .abort(abort), .auto_repeat(auto_repeat), .count(count), .forward(forward),
        .enable(enable), .finish(finish), .sweep_cnt(sweep_cnt), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which phase of the sweep we are in and where the count stands.
    int m_phase = P_IDLE;
    int m_cnt   = MIN_VAL;
    int m_sw    = 0;
    bit m_fwd   = 1;
    bit m_fin   = 0;

    always @(posedge clk or posedge reset) begin
        m_fin = 0;
        if (reset) begin
            m_phase = P_IDLE; m_cnt = MIN_VAL; m_fwd = 1; m_sw = 0;
        end else if (abort) begin
            m_phase = P_IDLE; m_cnt = MIN_VAL; m_fwd = 1;
        end else if (!pause) begin
            if (m_phase == P_IDLE && start) begin
                m_phase = P_UP; m_cnt = MIN_VAL; m_fwd = 1;
            end else if (m_phase == P_UP && tick) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == MAX_VAL) begin
                    m_fin = 1; m_phase = P_DOWN; m_fwd = 0;
                end
            end else if (m_phase == P_DOWN && tick) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == MIN_VAL) begin
                    m_fin = 1;
                    m_sw  = (m_sw < SW_TOP) ? m_sw + 1 : SW_TOP;
                    m_phase = auto_repeat ? P_UP : P_HOLD;
                    m_fwd = auto_repeat;
                end
            end else if (m_phase == P_HOLD) begin
                if (progressive) begin
                    m_phase = P_UP; m_cnt = MIN_VAL; m_fwd = 1;
                end else if (regressive) begin
                    m_phase = P_DOWN; m_cnt = MAX_VAL; m_fwd = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_count", int'(count), m_cnt);
            chk("model_state", int'(state_o), m_phase);
            chk("model_forward", int'(forward), int'(m_fwd));
            chk("model_finish", int'(finish), int'(m_fin));
            chk("model_sweep_cnt", int'(sweep_cnt), m_sw);
            chk("model_enable", int'(enable),
                int'((m_phase == P_UP || m_phase == P_DOWN) && !pause));
        end
    end

    task automatic cyc(input logic tk, input logic st, input logic pr, input logic rg,
                       input logic ab);
        tick = tk; start = st; progressive = pr; regressive = rg; abort = ab;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; progressive = 1'b0; regressive = 1'b0; abort = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    bit saw_hold;

    initial begin
        reset = 1'b1;
        tick = 1'b0; start = 1'b0; progressive = 1'b0; regressive = 1'b0;
        pause = 1'b0; abort = 1'b0; auto_repeat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1;

        chk("reset_count", int'(count), 0);
        chk("reset_state", int'(state_o), 0);
        chk("reset_forward", int'(forward), 1);
        chk("reset_sweep", int'(sweep_cnt), 0);

        ticks(3);
        chk("idle_ignores_tick", int'(count), 0);

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_state", int'(state_o), 1);
        ticks(8);
        chk("up_count8", int'(count), 8);
        chk("up_no_finish", int'(finish), 0);
        ticks(1);
        chk("top_count", int'(count), 9);
        chk("top_finish", int'(finish), 1);
        chk("top_forward", int'(forward), 0);
        chk("top_state", int'(state_o), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("finish_one_cycle", int'(finish), 0);

        ticks(9);
        chk("bottom_count", int'(count), 0);
        chk("bottom_finish", int'(finish), 1);
        chk("bottom_state", int'(state_o), 3);
        chk("bottom_enable", int'(enable), 0);
        chk("bottom_sweep", int'(sweep_cnt), 1);

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hold_ignores_start", int'(state_o), 3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("both_cmd_state", int'(state_o), 1);
        chk("both_cmd_count", int'(count), 0);

        ticks(18);
        chk("second_sweep", int'(sweep_cnt), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("regressive_count", int'(count), 9);
        chk("regressive_state", int'(state_o), 2);

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_state", int'(state_o), 0);
        chk("abort_count", int'(count), 0);
        chk("abort_keeps_sweep", int'(sweep_cnt), 2);

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        chk("pre_pause_count", int'(count), 4);
        pause = 1'b1;
        ticks(3);
        chk("pause_count", int'(count), 4);
        chk("pause_enable", int'(enable), 0);
        chk("pause_state", int'(state_o), 1);
        pause = 1'b0;
        ticks(1);
        chk("resume_count", int'(count), 5);

        ticks(4);
        ticks(3);
        chk("down_at6", int'(count), 6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_state", int'(state_o), 0);
        chk("async_forward", int'(forward), 1);
        chk("async_sweep", int'(sweep_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        auto_repeat = 1'b1;
        saw_hold = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 16; s++) begin
            for (int t = 0; t < 18; t++) begin
                ticks(1);
                if (state_o == 2'd3) saw_hold = 1;
            end
        end
        chk("auto_never_hold", int'(saw_hold), 0);
        chk("auto_sweep_sat", int'(sweep_cnt), 15);
        chk("auto_state_up", int'(state_o), 1);
        chk("auto_forward", int'(forward), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("auto_abort_state", int'(state_o), 0);
        chk("auto_abort_count", int'(count), 0);

        auto_repeat = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(18);
        chk("sat_hold_state", int'(state_o), 3);
        chk("sat_hold_sweep", int'(sweep_cnt), 15);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("cmd_tick_count", int'(count), 0);
        chk("cmd_tick_state", int'(state_o), 1);
        ticks(18);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reg_tick_count", int'(count), 9);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
